// File: rtl/pipeline_stage_reg.sv
// Elastic valid/ready register chain with synchronous flush and occupancy count.
// Define PIPELINE_SKID_EN for a skid register per stage and fully registered ready.
module pipeline_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int OCC_W  = $clog2(2*STAGES+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES:0]   vld;
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] busy;
  logic [WIDTH-1:0]  dat [STAGES+1];
  logic [1:0]        cnt [STAGES];

  assign vld[0]    = in_valid;
  assign dat[0]    = in_data;
  assign in_ready  = rdy[0] & ~RST;
  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];

  // Ready chain walks from the consumer back to the producer.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
`ifdef PIPELINE_SKID_EN
      rdy[i] = ~busy[i];
`else
      rdy[i] = ~busy[i] | rdy[i+1];
`endif
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(cnt[i]);
    end
  end

`ifdef PIPELINE_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             acc_in;
    logic             acc_out;
    logic [WIDTH-1:0] main_q;

    assign acc_in   = vld[i] & rdy[i];
    assign acc_out  = vld[i+1] & rdy[i+1];
    assign dat[i+1] = main_q;

`ifdef PIPELINE_SKID_EN
    state_t           st_q;
    state_t           st_d;
    logic [WIDTH-1:0] skid_q;
    logic             main_we;
    logic             skid_we;
    logic             from_skid;

    assign busy[i]  = (st_q == TWO);
    assign vld[i+1] = (st_q != EMPTY);
    assign cnt[i]   = (st_q == TWO) ? 2'd2 :
                      (st_q == ONE) ? 2'd1 : 2'd0;

    always_comb begin
      st_d      = st_q;
      main_we   = 1'b0;
      skid_we   = 1'b0;
      from_skid = 1'b0;
      unique case (st_q)
        EMPTY: begin
          if (acc_in) begin
            st_d    = ONE;
            main_we = 1'b1;
          end
        end
        ONE: begin
          if (acc_in && acc_out) begin
            main_we = 1'b1;
          end else if (acc_in) begin
            st_d    = TWO;
            skid_we = 1'b1;
          end else if (acc_out) begin
            st_d = EMPTY;
          end
        end
        TWO: begin
          if (acc_out) begin
            st_d      = ONE;
            main_we   = 1'b1;
            from_skid = 1'b1;
          end
        end
        default: st_d = EMPTY;
      endcase
      if (flush) begin
        st_d    = EMPTY;
        main_we = 1'b0;
        skid_we = 1'b0;
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) st_q <= EMPTY;
      else     st_q <= st_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (main_we) main_q <= from_skid ? skid_q : dat[i];
        if (skid_we) skid_q <= dat[i];
      end
    end
`else
    logic v_q;

    assign busy[i]  = v_q;
    assign vld[i+1] = v_q;
    assign cnt[i]   = {1'b0, v_q};

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        v_q    <= 1'b0;
        main_q <= '0;
      end else begin
        if (flush)        v_q <= 1'b0;
        else if (acc_in)  v_q <= 1'b1;
        else if (acc_out) v_q <= 1'b0;
        if (acc_in && !flush) main_q <= dat[i];
      end
    end
`endif
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg (WIDTH=32, STAGES=2).
module tb_pipeline_stage_reg;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int OCC_W  = $clog2(2*STAGES+1);
`ifdef PIPELINE_SKID_EN
  localparam int CAP  = 2*STAGES;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = STAGES;
  localparam bit SKID = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  pipeline_stage_reg #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] exp_q[$];
  int n_pass, n_total, n_out, n_acc;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Monitor: every output handshake is compared against the queue head.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL out_unexpected: got %h, required no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  // One clock; an accepted input is pushed as the expected output.
  task automatic cycle();
    @(negedge CLK);
    if (!RST && !flush && in_valid && in_ready) begin
      exp_q.push_back(in_data);
      n_acc++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int a0, o0, k;
    n_pass = 0; n_total = 0; n_out = 0; n_acc = 0;
    RST = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA_0000;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming
    out_ready = 1'b1;
    o0 = n_out;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      cycle();
      if (i == 1) begin
        check("stream_lat_valid", 32'(out_valid), 32'd0);
        check("stream_lat_occ", 32'(occupancy), 32'd1);
      end else begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_occ", 32'(occupancy), 32'd2);
      end
    end
    in_valid = 1'b0;
    cycle();
    check("stream_tail_valid", 32'(out_valid), 32'd1);
    cycle();
    check("stream_drain_occ", 32'(occupancy), 32'd0);
    check("stream_count", 32'(n_out - o0), 32'd8);

    // Backpressure
    out_ready = 1'b0;
    a0 = n_acc;
    o0 = n_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + 32'(n_acc - a0);
      cycle();
    end
    check("bp_accepted", 32'(n_acc - a0), 32'(CAP));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_occ", 32'(occupancy), 32'(CAP));
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_path", 32'(in_ready), SKID ? 32'd0 : 32'd1);
    k = 0;
    while ((n_acc - a0) < 8 && k < 40) begin
      in_data = 32'h10 + 32'(n_acc - a0);
      cycle();
      k++;
    end
    check("bp_all_accepted", 32'(n_acc - a0), 32'd8);
    in_valid = 1'b0;
    for (int i = 0; i < 2*STAGES+2; i++) cycle();
    check("bp_count", 32'(n_out - o0), 32'd8);
    check("bp_drain_occ", 32'(occupancy), 32'd0);

    // Flush with a live input
    out_ready = 1'b0;
    a0 = n_acc;
    o0 = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h40 + 32'(n_acc - a0);
      cycle();
    end
    check("fl_pre_occ", 32'(occupancy), SKID ? 32'd3 : 32'd2);
    in_data = 32'h0000_DEAD;
    flush   = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("fl_no_output", 32'(n_out - o0), 32'd0);

    // Flush together with an output handshake
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h50 + 32'(n_acc - a0);
      cycle();
    end
    in_valid = 1'b0;
    o0 = n_out;
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flo_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    check("flo_count", 32'(n_out - o0), 32'd1);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h20 + 32'(n_acc - a0);
      cycle();
    end
    check("mr_pre_occ", 32'(occupancy), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    exp_q.delete();
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", out_data, 32'd0);
    check("mr_occ", 32'(occupancy), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("mr_post_ready", 32'(in_ready), 32'd1);
    o0 = n_out;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h30;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("mr_count", 32'(n_out - o0), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
